// File: rtl/i2c_cfg_seq_if.sv
// Handshake and status bundle between the codec-init sequencer and its neighbours.
// The sequencer connects through master; the transmit stage and system controller use slave.
interface i2c_cfg_seq_if;
   logic        i_trigger;
   logic        i_ready;
   logic        o_start;
   logic [6:0]  o_addr;
   logic        o_mode;
   logic [15:0] o_reg_data;
   logic [3:0]  o_index;
   logic        o_busy;
   logic        o_done;
   logic        o_error;

   modport master (
      input  i_trigger, i_ready,
      output o_start, o_addr, o_mode, o_reg_data, o_index, o_busy, o_done, o_error
   );

   modport slave (
      output i_trigger, i_ready,
      input  o_start, o_addr, o_mode, o_reg_data, o_index, o_busy, o_done, o_error
   );
endinterface

// File: rtl/i2c_cfg_seq.sv
// WM8731 register-initialisation sequencer: after a power-up delay, it sends each table word
// as one I2C write through the start/ready handshake, and re-runs when triggered.
module i2c_cfg_seq #(
   parameter logic [6:0]  DEV_ADDR   = 7'h1A,
   parameter int unsigned N_REGS     = 11,
   parameter int unsigned PWR_CYCLES = 1024,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned BUSY_TMO   = 8
) (
   input logic            i_clk,
   input logic            i_rst_n,
   i2c_cfg_seq_if.master  bus
);

   localparam int unsigned MAX_A   = (PWR_CYCLES > GAP_CYCLES) ? PWR_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_A > BUSY_TMO) ? MAX_A : BUSY_TMO;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned WORD_W  = 16;

   typedef enum logic [2:0] {
      PWR_WAIT, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP, DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    index_q, index_d;
   logic [WORD_W-1:0]   reg_data_q, reg_data_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;

   // Codec setup words {reg_addr[6:0], data[8:0]}; unused slots read as zero.
   function automatic logic [WORD_W-1:0] table_word(input logic [IDX_W-1:0] idx);
      case (idx)
         4'd0:    table_word = 16'h1E00;
         4'd1:    table_word = 16'h001A;
         4'd2:    table_word = 16'h021A;
         4'd3:    table_word = 16'h047B;
         4'd4:    table_word = 16'h067B;
         4'd5:    table_word = 16'h08F8;
         4'd6:    table_word = 16'h0A06;
         4'd7:    table_word = 16'h0C00;
         4'd8:    table_word = 16'h0E01;
         4'd9:    table_word = 16'h1002;
         4'd10:   table_word = 16'h1201;
         default: table_word = 16'h0000;
      endcase
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= PWR_WAIT;
         cnt_q      <= '0;
         index_q    <= '0;
         reg_data_q <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         index_q    <= index_d;
         reg_data_q <= reg_data_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   // One counter serves the power-up, busy-timeout and gap phases, which never overlap.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      index_d    = index_q;
      reg_data_d = reg_data_q;
      error_d    = error_q;

      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == CNT_W'(PWR_CYCLES - 1)) begin
               cnt_d   = '0;
               index_d = '0;
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOAD: begin
            reg_data_d = table_word(index_q);
            if (bus.i_ready) state_d = START;
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!bus.i_ready) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (bus.i_ready) begin
               cnt_d   = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
               cnt_d = '0;
               if (index_q == IDX_W'(N_REGS - 1)) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + IDX_W'(1);
                  state_d = LOAD;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.i_trigger) begin
               index_d = '0;
               error_d = 1'b0;
               state_d = LOAD;
            end
         end
         default: state_d = PWR_WAIT;
      endcase

      // Status flags are registered copies of the next state.
      start_d = (state_d == START);
      busy_d  = (state_d == LOAD) || (state_d == START) || (state_d == WAIT_BUSY) ||
                (state_d == WAIT_DONE) || (state_d == GAP);
      done_d  = (state_d == DONE);
   end

   assign bus.o_start    = start_q;
   assign bus.o_addr     = DEV_ADDR;
   assign bus.o_mode     = 1'b0;
   assign bus.o_reg_data = reg_data_q;
   assign bus.o_index    = index_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_done     = done_q;
   assign bus.o_error    = error_q;

endmodule
